// File: rtl/fifo_pkg.sv
// rtl/fifo_pkg.sv - shared constants and types for the synchronous FIFO
//
// Purpose: default geometry of the pad-boundary FIFO plus the data and
//          pointer types built from it.
// Ports:   none (package).
package fifo_pkg;

   localparam int DATA_SIZE = 8;
   localparam int ADDR_SIZE = 4;
   localparam int DEPTH     = 1 << ADDR_SIZE;

   typedef logic [DATA_SIZE-1:0] data_t;

   // One extra MSB over the array index: the wrap bit that separates
   // "full" from "empty" when the index bits match.
   typedef logic [ADDR_SIZE:0] ptr_t;

endpackage

// File: rtl/fifo_mem.sv
// rtl/fifo_mem.sv - DEPTH x DATA_SIZE register file, sync write, async read
//
// Purpose: storage array of the FIFO. Writes land on the rising edge of clk;
//          the read port is combinational so the head word falls through.
// Macro:   FIFO_CLEAR_MEM_EN - when defined, rst_n (active-low, synchronous)
//          clears every entry to 0; otherwise the array has no reset.
// Ports:   clk    in  clock
//          rst_n  in  synchronous active-low clear (only with FIFO_CLEAR_MEM_EN)
//          we     in  write enable
//          waddr  in  write index
//          wdata  in  write data
//          raddr  in  read index
//          rdata  out read data, combinational from raddr
module fifo_mem
   import fifo_pkg::*;
#(
   parameter int MEM_DATA_SIZE = DATA_SIZE,
   parameter int MEM_ADDR_SIZE = ADDR_SIZE,
   parameter int MEM_DEPTH     = DEPTH
) (
   input  logic                     clk,
`ifdef FIFO_CLEAR_MEM_EN
   input  logic                     rst_n,
`endif
   input  logic                     we,
   input  logic [MEM_ADDR_SIZE-1:0] waddr,
   input  logic [MEM_DATA_SIZE-1:0] wdata,
   input  logic [MEM_ADDR_SIZE-1:0] raddr,
   output logic [MEM_DATA_SIZE-1:0] rdata
);

   logic [MEM_DATA_SIZE-1:0] mem [MEM_DEPTH];

`ifdef FIFO_CLEAR_MEM_EN
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < MEM_DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else if (we) begin
         mem[waddr] <= wdata;
      end
   end
`else
   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end
`endif

   assign rdata = mem[raddr];

endmodule

// File: rtl/fifo_top_sync.sv
// rtl/fifo_top_sync.sv - 16x8 single-clock first-word-fall-through FIFO
//
// Purpose: chip-boundary buffer between a producer and a consumer sharing
//          clk_pad. Holds pointers and flags; storage lives in fifo_mem.
// Macro:   FIFO_CLEAR_MEM_EN - when defined, reset also zeroes the memory.
// Ports:   clk_pad      in  clock, all state on its rising edge
//          rst_pad      in  synchronous active-low reset
//          wr_en_pad    in  write request, ignored while full
//          wr_data_pad  in  write data
//          rd_en_pad    in  read request (pop head), ignored while empty
//          rd_data_pad  out head-of-queue data (fall-through)
//          full_pad     out DEPTH entries held
//          empty_pad    out no entries held
module fifo_top_sync
   import fifo_pkg::*;
#(
   parameter int DATA_SIZE = fifo_pkg::DATA_SIZE,
   parameter int ADDR_SIZE = fifo_pkg::ADDR_SIZE,
   parameter int DEPTH     = fifo_pkg::DEPTH
) (
   input  logic                 clk_pad,
   input  logic                 rst_pad,
   input  logic                 wr_en_pad,
   input  logic [DATA_SIZE-1:0] wr_data_pad,
   input  logic                 rd_en_pad,
   output logic [DATA_SIZE-1:0] rd_data_pad,
   output logic                 full_pad,
   output logic                 empty_pad
);

   if (DEPTH != (1 << ADDR_SIZE)) begin : g_depth_check
      $error("fifo_top_sync: DEPTH must equal 2**ADDR_SIZE");
   end

   localparam logic [ADDR_SIZE:0] PTR_ONE = 1;

   logic [ADDR_SIZE:0] wr_ptr;
   logic [ADDR_SIZE:0] rd_ptr;
   logic               wr_acc;
   logic               rd_acc;

   // Qualifiers use the flags of the current (pre-edge) pointers, so a
   // simultaneous read+write on a full FIFO only pops and on an empty FIFO
   // only pushes.
   assign wr_acc = wr_en_pad && !full_pad;
   assign rd_acc = rd_en_pad && !empty_pad;

   assign empty_pad = (wr_ptr == rd_ptr);
   assign full_pad  = (wr_ptr[ADDR_SIZE-1:0] == rd_ptr[ADDR_SIZE-1:0]) &&
                      (wr_ptr[ADDR_SIZE] != rd_ptr[ADDR_SIZE]);

   always_ff @(posedge clk_pad) begin
      if (!rst_pad) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (wr_acc) wr_ptr <= wr_ptr + PTR_ONE;
         if (rd_acc) rd_ptr <= rd_ptr + PTR_ONE;
      end
   end

   fifo_mem #(
      .MEM_DATA_SIZE (DATA_SIZE),
      .MEM_ADDR_SIZE (ADDR_SIZE),
      .MEM_DEPTH     (DEPTH)
   ) u_mem (
      .clk   (clk_pad),
`ifdef FIFO_CLEAR_MEM_EN
      .rst_n (rst_pad),
`endif
      .we    (wr_acc),
      .waddr (wr_ptr[ADDR_SIZE-1:0]),
      .wdata (wr_data_pad),
      .raddr (rd_ptr[ADDR_SIZE-1:0]),
      .rdata (rd_data_pad)
   );

endmodule

// File: tb/tb_fifo_top_sync.sv
// tb/tb_fifo_top_sync.sv - directed self-checking bench for fifo_top_sync
module tb_fifo_top_sync;
   import fifo_pkg::*;

   logic  clk_pad = 1'b0;
   logic  rst_pad;
   logic  wr_en_pad;
   data_t wr_data_pad;
   logic  rd_en_pad;
   data_t rd_data_pad;
   logic  full_pad;
   logic  empty_pad;

   int vectors     = 0;
   int miscompares = 0;

   data_t q[$];
   int    cnt;
   bit    w, r;

   fifo_top_sync dut (
      .clk_pad     (clk_pad),
      .rst_pad     (rst_pad),
      .wr_en_pad   (wr_en_pad),
      .wr_data_pad (wr_data_pad),
      .rd_en_pad   (rd_en_pad),
      .rd_data_pad (rd_data_pad),
      .full_pad    (full_pad),
      .empty_pad   (empty_pad)
   );

   always #5 clk_pad = ~clk_pad;

   task automatic step();
      @(posedge clk_pad);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic we, input data_t d, input logic re);
      wr_en_pad   = we;
      wr_data_pad = d;
      rd_en_pad   = re;
   endtask

   initial begin
      // Reset for two edges
      rst_pad = 1'b0;
      drive(1'b0, 8'h00, 1'b0);
      step();
      step();
      chk("reset_empty", empty_pad, 1);
      chk("reset_full", full_pad, 0);
`ifdef FIFO_CLEAR_MEM_EN
      chk("reset_data", rd_data_pad, 8'h00);
`endif
      rst_pad = 1'b1;
      step();
      chk("idle_empty", empty_pad, 1);

      // Fill with 00..0F
      for (int i = 0; i < 16; i++) begin
         drive(1'b1, data_t'(i), 1'b0);
         step();
         chk("fill_empty", empty_pad, 0);
         chk("fill_full", full_pad, (i == 15) ? 1 : 0);
         chk("fill_head", rd_data_pad, 8'h00);
      end
      // 17th write ignored
      drive(1'b1, 8'hFF, 1'b0);
      step();
      chk("ovf_full", full_pad, 1);
      chk("ovf_head", rd_data_pad, 8'h00);

      // Drain 00..0F
      for (int i = 0; i < 16; i++) begin
         drive(1'b0, 8'h00, 1'b1);
         chk("drain_data", rd_data_pad, i);
         step();
         chk("drain_full", full_pad, 0);
         chk("drain_empty", empty_pad, (i == 15) ? 1 : 0);
      end
      // Read while empty must not move rd_ptr: next write must be visible
      drive(1'b0, 8'h00, 1'b1);
      step();
      chk("udf_empty", empty_pad, 1);
      drive(1'b1, 8'h77, 1'b0);
      step();
      chk("udf_wr_empty", empty_pad, 0);
      chk("udf_wr_data", rd_data_pad, 8'h77);
      drive(1'b0, 8'h00, 1'b1);
      step();
      chk("udf_rd_empty", empty_pad, 1);

      // Streaming with a scoreboard queue
      q.delete();
      for (int c = 0; c < 100; c++) begin
         w = ($urandom_range(3) != 0);
         r = ($urandom_range(1) != 0);
         drive(w, data_t'($urandom), r);
         cnt = q.size();
         chk("strm_empty", empty_pad, (cnt == 0) ? 1 : 0);
         chk("strm_full", full_pad, (cnt == 16) ? 1 : 0);
         if (cnt > 0) chk("strm_head", rd_data_pad, q[0]);
         step();
         if (r && cnt > 0) void'(q.pop_front());
         if (w && cnt < 16) q.push_back(wr_data_pad);
      end
      while (q.size() > 0) begin
         drive(1'b0, 8'h00, 1'b1);
         chk("strm_drain", rd_data_pad, q[0]);
         step();
         void'(q.pop_front());
      end
      drive(1'b0, 8'h00, 1'b0);
      chk("strm_final_empty", empty_pad, 1);

      // Full plus simultaneous write and read: pop only
      for (int i = 0; i < 16; i++) begin
         drive(1'b1, data_t'(8'h10 + i), 1'b0);
         step();
      end
      chk("bf_full", full_pad, 1);
      drive(1'b1, 8'hEE, 1'b1);
      step();
      chk("bf_full_after", full_pad, 0);
      chk("bf_head", rd_data_pad, 8'h11);
      for (int i = 0; i < 15; i++) begin
         drive(1'b0, 8'h00, 1'b1);
         chk("bf_data", rd_data_pad, 8'h11 + i);
         step();
         chk("bf_empty", empty_pad, (i == 14) ? 1 : 0);
      end

      // Empty plus simultaneous write and read: push only
      drive(1'b1, 8'hA5, 1'b1);
      step();
      chk("be_empty", empty_pad, 0);
      chk("be_full", full_pad, 0);
      chk("be_data", rd_data_pad, 8'hA5);
      drive(1'b0, 8'h00, 1'b1);
      step();
      chk("be_one_entry", empty_pad, 1);

      // Reset mid-operation
      for (int i = 0; i < 5; i++) begin
         drive(1'b1, data_t'(8'h50 + i), 1'b0);
         step();
      end
      chk("mid_pre_empty", empty_pad, 0);
      drive(1'b0, 8'h00, 1'b0);
      rst_pad = 1'b0;
      step();
      chk("mid_rst_empty", empty_pad, 1);
      chk("mid_rst_full", full_pad, 0);
      rst_pad = 1'b1;
      drive(1'b1, 8'h3C, 1'b0);
      step();
      chk("mid_wr_empty", empty_pad, 0);
      chk("mid_wr_data", rd_data_pad, 8'h3C);
      drive(1'b0, 8'h00, 1'b1);
      step();
      chk("mid_rd_empty", empty_pad, 1);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
